// File: rtl/avalon_pio_in_irq_pkg.sv
// Shared constants and helpers for the Avalon-MM input PIO with interrupt.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_CTRL     = 3'd4;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_sel_e;

  localparam int CTRL_EDGE_LSB = 0;
  localparam int CTRL_EDGE_MSB = 1;
  localparam int CTRL_IRQ_MODE = 2;
  localparam int CTRL_DEB_EN   = 3;
  localparam int CTRL_W        = 4;

  // Select code 3 is deliberately folded into "any edge".
  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input logic [1:0]  sel);
    logic [31:0] det;
    case (sel)
      EDGE_RISE: det = cur & ~prev;
      EDGE_FALL: det = ~cur & prev;
      default:   det = cur ^ prev;
    endcase
    return det;
  endfunction

endpackage

// File: rtl/avalon_pio_in_irq_if.sv
// Avalon-MM slave port bundle for the input PIO.
interface avalon_pio_in_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_in_irq_sync_debounce.sv
// Synchroniser, debounce prescaler and per-bit filter for the PIO inputs.
// o_update pulses in the cycle after o_filtered was loaded.
module pio_sync_debounce #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_deb_en,
  output logic [WIDTH-1:0] o_filtered,
  output logic             o_update
);

  localparam int PRESC_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]       r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_fill;
  logic [PRESC_W-1:0]     r_presc;
  logic [WIDTH-1:0]       r_sample;
  logic                   r_sample_ok;
  logic [WIDTH-1:0]       r_filtered;
  logic                   r_update;

  logic [WIDTH-1:0] w_sync_q;
  logic             w_sync_ok;
  logic             w_tick;
  logic [WIDTH-1:0] w_agree;
  logic [WIDTH-1:0] w_filt_next;
  logic             w_load;

  assign w_sync_q  = r_sync[SYNC_STAGES-1];
  // r_fill marks the chain as full so reset zeros are never mistaken for input.
  assign w_sync_ok = r_fill[SYNC_STAGES-1];
  assign w_tick    = i_deb_en && (r_presc == PRESC_LAST);
  assign w_agree   = ~(w_sync_q ^ r_sample);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_fill <= '0;
    end else begin
      r_sync[0] <= i_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    w_filt_next = r_filtered;
    w_load      = 1'b0;
    if (!i_deb_en) begin
      if (w_sync_ok) begin
        w_filt_next = w_sync_q;
        w_load      = 1'b1;
      end else begin
        w_filt_next = r_filtered;
      end
    end else if (w_tick && w_sync_ok && r_sample_ok) begin
      w_filt_next = (r_filtered & ~w_agree) | (w_sync_q & w_agree);
      w_load      = 1'b1;
    end else begin
      w_filt_next = r_filtered;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_sample    <= '0;
      r_sample_ok <= 1'b0;
      r_filtered  <= '0;
      r_update    <= 1'b0;
    end else begin
      r_filtered <= w_filt_next;
      r_update   <= w_load;
      if (!i_deb_en) begin
        r_presc     <= '0;
        r_sample_ok <= 1'b0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
        if (w_tick && w_sync_ok) begin
          r_sample    <= w_sync_q;
          r_sample_ok <= 1'b1;
        end
      end
    end
  end

  assign o_filtered = r_filtered;
  assign o_update   = r_update;

endmodule

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO: filtered inputs, sticky edge capture with W1C,
// and a maskable level- or edge-sourced interrupt.
module avalon_pio_in_irq
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_pio_in_irq_if.slave  bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0]  r_mask;
  logic [WIDTH-1:0]  r_cap;
  logic [CTRL_W-1:0] r_ctrl;
  logic [WIDTH-1:0]  r_edge_prev;
  logic              r_primed;
  logic [31:0]       r_readdata;

  logic [WIDTH-1:0]  w_filtered;
  logic              w_update;
  logic              w_wr;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  w_edges;
  logic [31:0]       w_rd_mux;
  logic              w_unused_wdata;

  pio_sync_debounce #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in       (in_port),
    .i_deb_en   (r_ctrl[CTRL_DEB_EN]),
    .o_filtered (w_filtered),
    .o_update   (w_update)
  );

  assign w_wr           = bus.chipselect && !bus.write_n;
  assign w_unused_wdata = ^bus.writedata;
  assign w_clr   = (w_wr && (bus.address == ADDR_EDGE_CAP)) ? bus.writedata[WIDTH-1:0] : '0;
  // Until primed, edge_prev may still hold the reset value, so detection is held off.
  assign w_edges = r_primed ? WIDTH'(edge_detect(32'(w_filtered), 32'(r_edge_prev),
                                                 r_ctrl[CTRL_EDGE_MSB:CTRL_EDGE_LSB]))
                            : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask      <= '0;
      r_cap       <= '0;
      r_ctrl      <= '0;
      r_edge_prev <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_edge_prev <= w_filtered;
      if (w_update) r_primed <= 1'b1;
      // A new edge wins over a simultaneous clear of the same bit.
      r_cap <= (r_cap & ~w_clr) | w_edges;
      if (w_wr && (bus.address == ADDR_IRQ_MASK)) r_mask <= bus.writedata[WIDTH-1:0];
      if (w_wr && (bus.address == ADDR_CTRL))     r_ctrl <= bus.writedata[CTRL_W-1:0];
    end
  end

  always_comb begin
    w_rd_mux = 32'h0;
    case (bus.address)
      ADDR_DATA:     w_rd_mux = 32'(w_filtered);
      ADDR_IRQ_MASK: w_rd_mux = 32'(r_mask);
      ADDR_EDGE_CAP: w_rd_mux = 32'(r_cap);
      ADDR_CTRL:     w_rd_mux = {28'h0, r_ctrl};
      default:       w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= 32'h0;
    else          r_readdata <= w_rd_mux;
  end

  assign bus.readdata = r_readdata;
  assign irq = r_ctrl[CTRL_IRQ_MODE] ? |(r_cap & r_mask) : |(w_filtered & r_mask);

endmodule

// File: doc/avalon_pio_in_irq.md
Name: avalon_pio_in_irq

Overview:
Parametrised Avalon-MM input PIO slave, the successor to the fixed-width switch port. Features:
- Configurable input width.
- Multi-stage synchroniser and optional tick-based debounce filter.
- Per-bit edge capture with selectable edge polarity and write-1-to-clear.
- Level- or edge-sourced maskable interrupt.

It sits between board-level inputs (switches, keys) and the CPU's Avalon-MM interconnect.

Parameters:
WIDTH, 18, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (2..4)
DEBOUNCE_CYCLES, 1000, clk cycles between debounce sample ticks (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  interrupt request, active high

Behaviour:
Reset and clocking:
- reset_n is asynchronous and active-low; clk is the clock.
- Reset clears all flops: readdata=0, irq=0, sync chain, filtered data, edge_prev, edge_capture, irq_mask, ctrl, prescaler, primed flag.

Register map (word addresses):
- 0 DATA: RO, filtered input, zero-extended.
- 2 IRQ_MASK: RW, bits[WIDTH-1:0].
- 3 EDGE_CAPTURE: read; a write clears every bit where writedata=1 (W1C).
- 4 CTRL: RW.
  - [1:0] edge_sel: 0 rising, 1 falling, 2 any, 3 treated as any.
  - [2] irq_mode: 0 level, 1 edge.
  - [3] deb_en.
  - Bits above [3] read 0.
- Other addresses: reads return 0; writes are ignored.
- A write occurs when chipselect=1 and write_n=0.

Read path:
- readdata is registered every cycle from the address mux, regardless of chipselect.
- Read latency is 1 cycle. Unused upper bits read 0.

Synchroniser:
- in_port passes through SYNC_STAGES flops; its output is sync_q.

Filter:
- deb_en=0: filtered data <= sync_q every cycle.
- deb_en=1: the prescaler counts 0..DEBOUNCE_CYCLES-1 and produces a one-cycle tick at wrap.
  - At each tick, sample_q <= sync_q.
  - Filtered bit i updates to sync_q[i] only when sync_q[i]==sample_q[i], i.e. two consecutive ticks agree.
  - A glitch shorter than one tick period never reaches filtered data.
- The prescaler runs only while deb_en=1 and resets to 0 when deb_en is cleared.
- Writing CTRL does not alter filtered data.

Edge detection:
- edge_prev <= filtered each cycle.
- Detected edges per edge_sel:
  - rising: filtered & ~edge_prev
  - falling: ~filtered & edge_prev
  - any: filtered ^ edge_prev
- edge_capture |= detected edges (sticky).
- When a W1C write and a new edge hit the same bit in the same cycle, set wins and the bit stays 1.

Startup:
- primed=0 after reset.
- The first filtered update loads filtered and edge_prev with the same value, produces no edge, and sets primed.
  - deb_en=0: this update occurs SYNC_STAGES cycles after reset release.
  - deb_en=1: this update occurs at the first tick pair.
- Inputs held high through reset therefore never generate a spurious edge.

Interrupt:
- irq is combinational from flops.
- irq_mode=0: irq = |(filtered & irq_mask).
- irq_mode=1: irq = |(edge_capture & irq_mask).
- Changing irq_mask takes effect on irq the cycle after the write.

Reset mid-operation:
- Asynchronous reset immediately returns every register to its reset value and re-arms the startup rule.

Decomposition:
- Package avalon_pio_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3, ADDR_CTRL=4.
  - Edge-select enum EDGE_RISE/EDGE_FALL/EDGE_ANY.
  - CTRL bit-position constants.
- One natural sub-module: pio_sync_debounce, covering synchroniser, prescaler and filter for WIDTH bits, with output filtered and an update strobe.
- The top level holds the register file, edge capture, irq and read mux.

Test Plan:
1. Reset with in_port=18'h3FFFF held high, deb_en=0 -> DATA reads 32'h3FFFF by cycle SYNC_STAGES+2; EDGE_CAPTURE reads 0; irq=0.
2. Write IRQ_MASK=0x5, CTRL=0 (level), then drive in_port=0x4 -> irq=1 SYNC_STAGES+1 cycles later. Drive in_port=0x8 -> irq=0.
3. CTRL=0x4 (edge, rising), IRQ_MASK=0x1; pulse in_port[0] high for 5 cycles -> EDGE_CAPTURE=0x1 and irq=1. Write 0x1 to address 3 -> EDGE_CAPTURE=0 and irq=0.
4. With edge_sel=1 (falling), a rising in_port[1] -> no capture; the following falling edge -> EDGE_CAPTURE=0x2. With edge_sel=2, both edges capture.
5. Issue a W1C write to bit 0 in the same cycle as a new rising edge on bit 0 -> EDGE_CAPTURE[0] stays 1.
6. DEBOUNCE_CYCLES=8, deb_en=1:
   - A 5-cycle glitch on in_port[2] -> DATA unchanged.
   - Holding the input for 20 cycles -> DATA[2]=1 within 2 tick periods plus SYNC_STAGES.
   - Reading address 5 -> 0.
